uart_rx_fifo: RTL and testbench

- Receive-side byte FIFO between the UART receiver's AXI-stream output and the CSR block's UART data/status registers.
- Decouples CPU polling latency from line rate.
- Never back-pressures the UART. Drops bytes when full and records a sticky overrun.
- Exposes head byte, non-empty flag and fill level to the CSR bank.

---
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO feeding the CSR data/status registers
//
// Sits between the UART receiver stream and the CSR bank. The UART is never
// back-pressured: bytes arriving while the FIFO is full are dropped and a
// sticky overrun flag is raised. The head byte is presented show-ahead.
//
// Optional feature macro: RX_FIFO_WATERMARK_EN
//   defined   : irq_o is a registered level-watermark / overrun interrupt
//   undefined : irq_o is tied low and watermark_i is ignored

module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  rd_strobe_i,
   output logic [7:0]            rd_data_o,
   output logic                  not_empty_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  overrun_o,
   input  logic                  overrun_clr_i,
   input  logic                  flush_i,
   input  logic [DEPTH_LOG2:0]   watermark_i,
   output logic                  irq_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Level value that means "every slot occupied".
   localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q,  level_d;
   logic                  overrun_q, overrun_d;

   logic                  full;
   logic                  empty;
   logic                  push_req;
   logic                  push_acc;
   logic                  pop;
   logic                  drop;

   // Ready simply mirrors reset: the FIFO absorbs or drops, it never stalls.
   assign s_axis_tready = ~rst_i;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);

   // Event decode: flush cancels both sides; a full FIFO still accepts a byte
   // when the head is being popped in the same cycle.
   always_comb begin
      push_req = s_axis_tvalid & s_axis_tready & ~flush_i;
      pop      = rd_strobe_i & ~empty & ~flush_i;
      push_acc = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   // Next-state for pointers, level and the sticky overrun flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      overrun_d = overrun_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_acc, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end

      // A fresh drop beats a simultaneous clear so no overrun is ever lost.
      if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

   // Byte storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_acc) begin
         mem[wr_ptr_q] <= s_axis_tdata;
      end
   end

   assign rd_data_o   = empty ? 8'h00 : mem[rd_ptr_q];
   assign not_empty_o = ~empty;
   assign level_o     = level_q;
   assign overrun_o   = overrun_q;

`ifdef RX_FIFO_WATERMARK_EN
   logic irq_q, irq_d;

   // Interrupt follows the registered level/overrun, one cycle behind them.
   always_comb begin
      irq_d = ((watermark_i != '0) & (level_q >= watermark_i)) | overrun_q;
   end

   // Interrupt register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_watermark;

   assign unused_watermark = ^watermark_i;
   assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for uart_rx_fifo (DEPTH_LOG2=4)

module tb_uart_rx_fifo;

   localparam int DL2 = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     tdata;
   logic           tvalid;
   logic           tready;
   logic           rd;
   logic [7:0]     rdat;
   logic           ne;
   logic [DL2:0]   lvl;
   logic           ov;
   logic           clr;
   logic           flush;
   logic [DL2:0]   wm;
   logic           irq;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .rd_strobe_i   (rd),
      .rd_data_o     (rdat),
      .not_empty_o   (ne),
      .level_o       (lvl),
      .overrun_o     (ov),
      .overrun_clr_i (clr),
      .flush_i       (flush),
      .watermark_i   (wm),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       f;
      logic       c;
      logic [4:0] e_lvl;
      logic       e_ne;
      logic [7:0] e_rd;
      logic       e_ov;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                               input logic f, input logic c, input logic [4:0] el,
                               input logic ene, input logic [7:0] erd, input logic eov);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.f = f; t.c = c;
      t.e_lvl = el; t.e_ne = ene; t.e_rd = erd; t.e_ov = eov;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic c);
      tvalid = v; tdata = d; rd = r; flush = f; clr = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // state packed as {lvl, ne, rd_data, ov}
   function automatic logic [31:0] st(input logic [4:0] l, input logic n,
                                      input logic [7:0] d, input logic o);
      return {17'd0, l, n, d, o};
   endfunction

   initial begin
      logic [7:0] got;
      int         errs;
      int         maxl;

      rst = 1'b1;
      wm  = '0;
      idle();

      // table: one cycle per row, outputs checked after the edge
      vecs[0]  = mk(1, 8'h41, 0, 0, 0, 5'd1, 1, 8'h41, 0);
      vecs[1]  = mk(1, 8'h42, 0, 0, 0, 5'd2, 1, 8'h41, 0);
      vecs[2]  = mk(1, 8'h43, 0, 0, 0, 5'd3, 1, 8'h41, 0);
      vecs[3]  = mk(0, 8'h00, 1, 0, 0, 5'd2, 1, 8'h42, 0);
      vecs[4]  = mk(0, 8'h00, 1, 0, 0, 5'd1, 1, 8'h43, 0);
      vecs[5]  = mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 8'h00, 0);
      vecs[6]  = mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 8'h00, 0);
      vecs[7]  = mk(1, 8'h55, 1, 0, 0, 5'd1, 1, 8'h55, 0);
      vecs[8]  = mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 8'h00, 0);
      vecs[9]  = mk(1, 8'h01, 0, 0, 0, 5'd1, 1, 8'h01, 0);
      vecs[10] = mk(1, 8'h02, 0, 0, 0, 5'd2, 1, 8'h01, 0);
      vecs[11] = mk(1, 8'h03, 0, 0, 0, 5'd3, 1, 8'h01, 0);
      vecs[12] = mk(1, 8'h04, 0, 0, 0, 5'd4, 1, 8'h01, 0);
      vecs[13] = mk(1, 8'h05, 0, 0, 0, 5'd5, 1, 8'h01, 0);
      vecs[14] = mk(1, 8'h77, 1, 1, 0, 5'd0, 0, 8'h00, 0);
      vecs[15] = mk(0, 8'h00, 0, 0, 0, 5'd0, 0, 8'h00, 0);
      vecs[16] = mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 8'h00, 0);
      vecs[17] = mk(1, 8'h12, 0, 0, 0, 5'd1, 1, 8'h12, 0);
      vecs[18] = mk(0, 8'h00, 1, 0, 0, 5'd0, 0, 8'h00, 0);

      // reset state
      tick();
      check("reset_tready", {31'd0, tready}, 32'd0);
      check("reset_state", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 0));
      check("reset_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      #1;
      check("tready_after_reset", {31'd0, tready}, 32'd1);

      // directed table
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].c);
         tick();
         check($sformatf("vec%0d", i), st(lvl, ne, rdat, ov),
               st(vecs[i].e_lvl, vecs[i].e_ne, vecs[i].e_rd, vecs[i].e_ov));
      end
      idle();

      // overflow: 17 pushes into 16 slots
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
         if (i == 15) check("fill16_no_ov", st(lvl, ne, rdat, ov), st(5'd16, 1, 8'h00, 0));
      end
      idle();
      check("ovf_state", st(lvl, ne, rdat, ov), st(5'd16, 1, 8'h00, 1));
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (rdat !== 8'(i)) errs++;
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      idle();
      check("ovf_drain_order_errs", errs, 0);
      check("ovf_drained", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 1));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      check("ov_cleared", {31'd0, ov}, 32'd0);

      // push + pop while full
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      check("full_pushpop", st(lvl, ne, rdat, ov), st(5'd16, 1, 8'h81, 0));
      for (int i = 0; i < 16; i++) begin
         got = rdat;
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      idle();
      check("full_pushpop_last", {24'd0, got}, 32'h99);
      check("full_pushpop_empty", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 0));

      // overrun vs clear priority, flush keeps overrun
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      check("ov_set", st(lvl, ne, rdat, ov), st(5'd16, 1, 8'hA0, 1));
      drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      tick();
      check("ov_beats_clr", st(lvl, ne, rdat, ov), st(5'd16, 1, 8'hA0, 1));
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      check("flush_keeps_ov", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 1));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      check("ov_clr2", {31'd0, ov}, 32'd0);

      // wrap-around: 40 bytes, each pushed while the previous is popped
      errs = 0;
      maxl = 0;
      drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 1; i < 40; i++) begin
         if (rdat !== 8'(i - 1)) errs++;
         drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
         tick();
         if (int'(lvl) > maxl) maxl = int'(lvl);
      end
      if (rdat !== 8'd39) errs++;
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      check("wrap_order_errs", errs, 0);
      check("wrap_level_le2", {31'd0, (maxl <= 2)}, 32'd1);
      check("wrap_end_empty", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 0));

      // reset mid-operation; strobe during reset ignored
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("async_reset", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 0));
      tick();
      idle();
      rst = 1'b0;
      tick();
      check("after_mid_reset", st(lvl, ne, rdat, ov), st(5'd0, 0, 8'h00, 0));

`ifdef RX_FIFO_WATERMARK_EN
      wm = 5'd4;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      check("wm_lvl4_irq_lag", {26'd0, lvl, irq}, {26'd0, 5'd4, 1'b0});
      tick();
      check("wm_irq_rise", {31'd0, irq}, 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      check("wm_lvl3_irq_hold", {26'd0, lvl, irq}, {26'd0, 5'd3, 1'b1});
      tick();
      check("wm_irq_fall", {31'd0, irq}, 32'd0);
      wm = 5'd0;
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle();
      check("wm0_ov_no_irq_yet", {30'd0, ov, irq}, {30'd0, 1'b1, 1'b0});
      tick();
      check("wm0_ov_irq", {31'd0, irq}, 32'd1);
`else
      wm = 5'd1;
      drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      idle();
      check("irq_tied_low", {31'd0, irq}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
